// File: rtl/tuser_in_split_fsm_if.sv
// Stream and tuple bundle for tuser_in_split_fsm.
// master = upstream source / downstream sink side, slave = the splitter.
interface tuser_in_split_fsm_if;
   logic         tin_avalid;
   logic         tin_aready;
   logic [255:0] tin_adata;
   logic [31:0]  tin_akeep;
   logic         tin_atlast;
   logic [127:0] tin_atuser;

   logic         tin_bvalid;
   logic         tin_bready;
   logic [255:0] tin_bdata;
   logic [31:0]  tin_bkeep;
   logic         tin_btlast;

   logic         tin_valid;
   logic [127:0] tin_data;

   modport master (
      output tin_avalid, tin_adata, tin_akeep, tin_atlast, tin_atuser, tin_bready,
      input  tin_aready, tin_bvalid, tin_bdata, tin_bkeep, tin_btlast, tin_valid, tin_data
   );

   modport slave (
      input  tin_avalid, tin_adata, tin_akeep, tin_atlast, tin_atuser, tin_bready,
      output tin_aready, tin_bvalid, tin_bdata, tin_bkeep, tin_btlast, tin_valid, tin_data
   );
endinterface

// File: rtl/tuser_in_split_fsm.sv
// Splits per-packet tuser metadata off an AXI4-Stream packet stream.
// Data beats pass through one registered stage; the first-beat tuser is
// emitted as a one-cycle tuple pulse aligned with the first output beat.
//
//   state | meaning
//   ------+-----------------------------------------
//   IDLE  | 000: waiting for the first beat of a packet
//   WRDN  | 001: inside a packet, tuser ignored
//   other | illegal, returns to IDLE on the next edge
module tuser_in_split_fsm #(
   parameter int unsigned MAX_BEATS = 64
) (
   input  logic                  tin_aclk,
   input  logic                  tin_arst_n,
   tuser_in_split_fsm_if.slave   bus,
   output logic                  tin_err,
   output logic [2:0]            dbg_state
);

   typedef enum logic [2:0] {
      IDLE = 3'b000,
      WRDN = 3'b001
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          tvalid_q, tvalid_d;
   logic [127:0]  tdata_q, tdata_d;
   logic          bvalid_q, bvalid_d;
   logic [255:0]  bdata_q, bdata_d;
   logic [31:0]   bkeep_q, bkeep_d;
   logic          btlast_q, btlast_d;

   logic          aready;
   logic          accept;
   logic [15:0]   cnt_inc;

   assign aready  = !bvalid_q || bus.tin_bready;
   assign accept  = bus.tin_avalid && aready;
   assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   // Output beat register: load on accept, drop valid once drained.
   always_comb begin
      bvalid_d = bvalid_q;
      bdata_d  = bdata_q;
      bkeep_d  = bkeep_q;
      btlast_d = btlast_q;
      if (accept) begin
         bvalid_d = 1'b1;
         bdata_d  = bus.tin_adata;
         bkeep_d  = bus.tin_akeep;
         btlast_d = bus.tin_atlast;
      end else if (bus.tin_bready) begin
         bvalid_d = 1'b0;
      end
   end

   // Packet FSM: tuple capture on first beat, beat counting and overrun flag.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      tvalid_d = 1'b0;
      tdata_d  = tdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               tvalid_d = 1'b1;
               tdata_d  = bus.tin_atuser;
               cnt_d    = 16'd1;
               state_d  = bus.tin_atlast ? IDLE : WRDN;
            end
         end
         WRDN: begin
            if (accept) begin
               cnt_d = cnt_inc;
               if ({16'd0, cnt_inc} > MAX_BEATS) begin
                  err_d = 1'b1;
               end
               if (bus.tin_atlast) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge tin_aclk or negedge tin_arst_n) begin
      if (!tin_arst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         bvalid_q <= 1'b0;
         bdata_q  <= '0;
         bkeep_q  <= '0;
         btlast_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         bvalid_q <= bvalid_d;
         bdata_q  <= bdata_d;
         bkeep_q  <= bkeep_d;
         btlast_q <= btlast_d;
      end
   end

   assign bus.tin_aready = aready;
   assign bus.tin_bvalid = bvalid_q;
   assign bus.tin_bdata  = bdata_q;
   assign bus.tin_bkeep  = bkeep_q;
   assign bus.tin_btlast = btlast_q;
   assign bus.tin_valid  = tvalid_q;
   assign bus.tin_data   = tdata_q;
   assign tin_err        = err_q;
   assign dbg_state      = state_q;

endmodule
